// File: rtl/presc_pkg.sv
// Shared types and constants for the burst prescaler.
// Holds the FSM state encoding and the smallest usable divisor.
package presc_pkg;

  typedef enum logic {
    PRESC_IDLE,
    PRESC_RUN
  } presc_state_e;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/presc_burst_if.sv
// Control and output bundle between the SPI master FSM and the burst prescaler.
// The master drives the requests and operands; the slave (prescaler) drives the clock, strobes and status.
interface presc_burst_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
);

  logic             start_p;
  logic             stop_p;
  logic [DIV_W-1:0] div_p;
  logic [CNT_W-1:0] cnt_p;
  logic             clk_out_p;
  logic             lead_tick_p;
  logic             trail_tick_p;
  logic             busy_p;
  logic             done_p;

  modport master (
    output start_p, stop_p, div_p, cnt_p,
    input  clk_out_p, lead_tick_p, trail_tick_p, busy_p, done_p
  );

  modport slave (
    input  start_p, stop_p, div_p, cnt_p,
    output clk_out_p, lead_tick_p, trail_tick_p, busy_p, done_p
  );

endinterface

// File: rtl/presc_burst.sv
// Divides clk_in_p by a runtime divisor and emits P output periods, or runs until stopped.
// Latency: outputs registered, active level and lead tick appear right after the start edge.
// Backpressure: none; start is ignored while busy, stop only ends at a period boundary.
module presc_burst
  import presc_pkg::*;
#(
  parameter int   DIV_W    = 8,
  parameter int   CNT_W    = 8,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic          clk_in_p,
  input  logic          rst_p,
  presc_burst_if.slave  bus
);

  presc_state_e     state;
  logic [DIV_W-1:0] neff;
  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] ph;
  logic [CNT_W-1:0] rem;
  logic             cont;
  logic             stop_pend;

  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] ph_next;
  logic             at_bnd;
  logic             leave;
  logic             take_start;

  always_comb begin
    div_eff    = (bus.div_p < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : bus.div_p;
    at_bnd     = (ph == neff - 1'b1);
    ph_next    = at_bnd ? '0 : ph + 1'b1;
    // A stop arriving in the boundary cycle itself still ends the run there.
    leave      = at_bnd && (stop_pend || bus.stop_p || (!cont && rem == CNT_W'(1)));
    take_start = bus.start_p && !bus.stop_p;
  end

  always_ff @(posedge clk_in_p or posedge rst_p) begin
    if (rst_p) begin
      state            <= PRESC_IDLE;
      neff             <= '0;
      half             <= '0;
      ph               <= '0;
      rem              <= '0;
      cont             <= 1'b0;
      stop_pend        <= 1'b0;
      bus.clk_out_p    <= IDLE_LVL;
      bus.lead_tick_p  <= 1'b0;
      bus.trail_tick_p <= 1'b0;
      bus.busy_p       <= 1'b0;
      bus.done_p       <= 1'b0;
    end else begin
      case (state)
        PRESC_IDLE: begin
          bus.done_p       <= 1'b0;
          bus.lead_tick_p  <= 1'b0;
          bus.trail_tick_p <= 1'b0;
          if (take_start) begin
            state           <= PRESC_RUN;
            neff            <= div_eff;
            half            <= div_eff >> 1;
            rem             <= bus.cnt_p;
            cont            <= (bus.cnt_p == '0);
            stop_pend       <= 1'b0;
            ph              <= '0;
            bus.clk_out_p   <= ~IDLE_LVL;
            bus.lead_tick_p <= 1'b1;
            bus.busy_p      <= 1'b1;
          end
        end
        PRESC_RUN: begin
          if (leave) begin
            state            <= PRESC_IDLE;
            ph               <= '0;
            rem              <= cont ? rem : rem - 1'b1;
            stop_pend        <= 1'b0;
            bus.clk_out_p    <= IDLE_LVL;
            bus.lead_tick_p  <= 1'b0;
            bus.trail_tick_p <= 1'b0;
            bus.busy_p       <= 1'b0;
            bus.done_p       <= 1'b1;
          end else begin
            ph               <= ph_next;
            if (at_bnd && !cont)
              rem <= rem - 1'b1;
            stop_pend        <= stop_pend | bus.stop_p;
            // half >= 1 because neff >= 2, so lead and trail never coincide.
            bus.clk_out_p    <= (ph_next < half) ? ~IDLE_LVL : IDLE_LVL;
            bus.lead_tick_p  <= (ph_next == '0);
            bus.trail_tick_p <= (ph_next == half);
          end
        end
        default: begin
          state      <= PRESC_IDLE;
          bus.busy_p <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_presc_burst.sv
// Directed bench for presc_burst: two instances (IDLE_LVL 0 and 1) share one stimulus stream.
module tb_presc_burst;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [7:0] div;
  logic [7:0] cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] c_clk0, c_lead0, c_trail0, c_busy0, c_done0;
  logic [31:0] c_clk1, c_lead1, c_trail1;

  presc_burst_if #(.DIV_W(8), .CNT_W(8)) if0 ();
  presc_burst_if #(.DIV_W(8), .CNT_W(8)) if1 ();

  assign if0.start_p = start;
  assign if0.stop_p  = stop;
  assign if0.div_p   = div;
  assign if0.cnt_p   = cnt;
  assign if1.start_p = start;
  assign if1.stop_p  = stop;
  assign if1.div_p   = div;
  assign if1.cnt_p   = cnt;

  presc_burst #(.DIV_W(8), .CNT_W(8), .IDLE_LVL(1'b0)) dut0 (
    .clk_in_p (clk),
    .rst_p    (rst),
    .bus      (if0.slave)
  );

  presc_burst #(.DIV_W(8), .CNT_W(8), .IDLE_LVL(1'b1)) dut1 (
    .clk_in_p (clk),
    .rst_p    (rst),
    .bus      (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples n cycles (first sample lands in the MSB of the n-bit window).
  // At iteration poke_at the operands change and start pulses; stop pulses at stop_at.
  task automatic capture(input int n, input int poke_at, input int stop_at);
    c_clk0 = '0; c_lead0 = '0; c_trail0 = '0; c_busy0 = '0; c_done0 = '0;
    c_clk1 = '0; c_lead1 = '0; c_trail1 = '0;
    for (int i = 0; i < n; i++) begin
      c_clk0   = {c_clk0[30:0],   if0.clk_out_p};
      c_lead0  = {c_lead0[30:0],  if0.lead_tick_p};
      c_trail0 = {c_trail0[30:0], if0.trail_tick_p};
      c_busy0  = {c_busy0[30:0],  if0.busy_p};
      c_done0  = {c_done0[30:0],  if0.done_p};
      c_clk1   = {c_clk1[30:0],   if1.clk_out_p};
      c_lead1  = {c_lead1[30:0],  if1.lead_tick_p};
      c_trail1 = {c_trail1[30:0], if1.trail_tick_p};
      if (i == poke_at) begin div = 8'd7; cnt = 8'd1; start = 1'b1; end
      if (i == poke_at + 1) start = 1'b0;
      if (i == stop_at) stop = 1'b1;
      if (i == stop_at + 1) stop = 1'b0;
      tick();
    end
  endtask

  task automatic chk_end(input string tag);
    chk({tag, " done"},  {31'd0, if0.done_p},    32'd1);
    chk({tag, " busy"},  {31'd0, if0.busy_p},    32'd0);
    chk({tag, " idle"},  {31'd0, if0.clk_out_p}, 32'd0);
    chk({tag, " lead"},  {31'd0, if0.lead_tick_p}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; div = 8'd0; cnt = 8'd0;
    #1 rst = 1'b1;
    #2;
    chk("rst clk0",   {31'd0, if0.clk_out_p},    32'd0);
    chk("rst clk1",   {31'd0, if1.clk_out_p},    32'd1);
    chk("rst busy",   {31'd0, if0.busy_p},       32'd0);
    chk("rst done",   {31'd0, if0.done_p},       32'd0);
    chk("rst ticks",  {30'd0, if0.lead_tick_p, if0.trail_tick_p}, 32'd0);
    chk("rst busy1",  {31'd0, if1.busy_p},       32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Even burst: N=4, P=3
    div = 8'd4; cnt = 8'd3; start = 1'b1;
    tick(); start = 1'b0;
    capture(12, -1, -1);
    chk("even clk",   c_clk0,   32'b110011001100);
    chk("even lead",  c_lead0,  32'b100010001000);
    chk("even trail", c_trail0, 32'b001000100010);
    chk("even busy",  c_busy0,  32'hFFF);
    chk("even nodone", c_done0, 32'd0);
    chk_end("even");
    tick();
    chk("even done clr", {31'd0, if0.done_p}, 32'd0);

    // Odd divisor: N=5, P=2
    div = 8'd5; cnt = 8'd2; start = 1'b1;
    tick(); start = 1'b0;
    capture(10, -1, -1);
    chk("odd clk",   c_clk0,   32'b1100011000);
    chk("odd lead",  c_lead0,  32'b1000010000);
    chk("odd trail", c_trail0, 32'b0010000100);
    chk("odd busy",  c_busy0,  32'h3FF);
    chk_end("odd");
    tick();

    // Clamp div=0 -> Neff 2, both polarities
    div = 8'd0; cnt = 8'd4; start = 1'b1;
    tick(); start = 1'b0;
    capture(8, -1, -1);
    chk("clamp0 clk0",   c_clk0,   32'b10101010);
    chk("clamp0 lead0",  c_lead0,  32'b10101010);
    chk("clamp0 trail0", c_trail0, 32'b01010101);
    chk("clamp0 clk1",   c_clk1,   32'b01010101);
    chk("clamp0 lead1",  c_lead1,  32'b10101010);
    chk("clamp0 trail1", c_trail1, 32'b01010101);
    chk_end("clamp0");
    chk("clamp0 idle1", {31'd0, if1.clk_out_p}, 32'd1);
    chk("clamp0 done1", {31'd0, if1.done_p},    32'd1);
    tick();

    // Clamp div=1
    div = 8'd1; cnt = 8'd4; start = 1'b1;
    tick(); start = 1'b0;
    capture(8, -1, -1);
    chk("clamp1 clk0", c_clk0, 32'b10101010);
    chk("clamp1 clk1", c_clk1, 32'b01010101);
    chk("clamp1 busy", c_busy0, 32'hFF);
    chk_end("clamp1");
    chk("clamp1 busy1", {31'd0, if1.busy_p}, 32'd0);
    tick();

    // Continuous N=6, stop sampled at edge T+8
    div = 8'd6; cnt = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    capture(12, -1, 7);
    chk("cont clk",   c_clk0,   32'b111000111000);
    chk("cont lead",  c_lead0,  32'b100000100000);
    chk("cont trail", c_trail0, 32'b000100000100);
    chk("cont busy",  c_busy0,  32'hFFF);
    chk("cont nodone", c_done0, 32'd0);
    chk_end("cont");
    tick();

    // Start and stop together in idle: stop wins; stop alone is ignored
    div = 8'd4; cnt = 8'd2; start = 1'b1; stop = 1'b1;
    tick();
    chk("ss busy", {31'd0, if0.busy_p},      32'd0);
    chk("ss clk",  {31'd0, if0.clk_out_p},   32'd0);
    chk("ss lead", {31'd0, if0.lead_tick_p}, 32'd0);
    start = 1'b0;
    tick(); stop = 1'b0;
    chk("stop idle busy", {31'd0, if0.busy_p}, 32'd0);
    chk("stop idle done", {31'd0, if0.done_p}, 32'd0);

    // Ignored inputs during a burst, then back-to-back start in the done cycle
    div = 8'd4; cnt = 8'd3; start = 1'b1;
    tick(); start = 1'b0;
    capture(12, 5, -1);
    chk("ign clk",   c_clk0,   32'b110011001100);
    chk("ign lead",  c_lead0,  32'b100010001000);
    chk("ign trail", c_trail0, 32'b001000100010);
    chk("ign busy",  c_busy0,  32'hFFF);
    chk_end("ign");
    div = 8'd2; cnt = 8'd1; start = 1'b1;
    tick(); start = 1'b0;
    chk("b2b busy", {31'd0, if0.busy_p},      32'd1);
    chk("b2b clk",  {31'd0, if0.clk_out_p},   32'd1);
    chk("b2b lead", {31'd0, if0.lead_tick_p}, 32'd1);
    chk("b2b done", {31'd0, if0.done_p},      32'd0);
    tick();
    chk("b2b trail", {30'd0, if0.clk_out_p, if0.trail_tick_p}, 32'b01);
    tick();
    chk_end("b2b");
    tick();

    // Asynchronous reset mid-run, between clock edges
    div = 8'd4; cnt = 8'd3; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("pre-rst clk", {31'd0, if0.clk_out_p}, 32'd1);
    rst = 1'b1;
    #2;
    chk("arst clk0", {31'd0, if0.clk_out_p}, 32'd0);
    chk("arst clk1", {31'd0, if1.clk_out_p}, 32'd1);
    chk("arst busy", {31'd0, if0.busy_p},    32'd0);
    chk("arst outs", {29'd0, if0.lead_tick_p, if0.trail_tick_p, if0.done_p}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post-rst done", {31'd0, if0.done_p}, 32'd0);
    chk("post-rst busy", {31'd0, if0.busy_p}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
